// File: rtl/key_exp_pkg.sv
// rtl/key_exp_pkg.sv - shared types, constants and helpers for AES key-expansion sequencing
package key_exp_pkg;

   localparam logic [1:0] CONF_128 = 2'd0;
   localparam logic [1:0] CONF_192 = 2'd1;
   localparam logic [1:0] CONF_256 = 2'd2;

   localparam logic [5:0] NK_128    = 6'd4;
   localparam logic [5:0] NK_192    = 6'd6;
   localparam logic [5:0] NK_256    = 6'd8;
   localparam logic [5:0] TOTAL_128 = 6'd44;
   localparam logic [5:0] TOTAL_192 = 6'd52;
   localparam logic [5:0] TOTAL_256 = 6'd60;

   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_WAIT_SUB = 3'd2,
      ST_CALC     = 3'd3,
      ST_DONE     = 3'd4
   } state_e;

   // Encoding 3 is an alias of AES-256 and is folded at latch time.
   function automatic logic [1:0] conf_norm(input logic [1:0] conf);
      return (conf == 2'd3) ? CONF_256 : conf;
   endfunction

   function automatic logic [5:0] nk_of(input logic [1:0] conf);
      case (conf)
         CONF_128: return NK_128;
         CONF_192: return NK_192;
         default:  return NK_256;
      endcase
   endfunction

   function automatic logic [5:0] total_of(input logic [1:0] conf);
      case (conf)
         CONF_128: return TOTAL_128;
         CONF_192: return TOTAL_192;
         default:  return TOTAL_256;
      endcase
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/key_exp_ctrl_if.sv
// rtl/key_exp_ctrl_if.sv - control/handshake bundle between key interface, controller and datapath
interface key_exp_ctrl_if;
   logic       start_in;
   logic [1:0] conf_in;
   logic       key_valid_in;
   logic       key_ready_out;
   logic       ready_in;
   logic       buff_en_out;
   logic [1:0] conf_out;
   logic       sel_key_out;
   logic       rot_sub_out;
   logic       sub_only_out;
   logic [7:0] rcon_out;
   logic [5:0] word_idx_out;
   logic       word_valid_out;
   logic       busy_out;
   logic       done_out;

   modport slave (
      input  start_in, conf_in, key_valid_in, ready_in,
      output key_ready_out, buff_en_out, conf_out, sel_key_out, rot_sub_out,
             sub_only_out, rcon_out, word_idx_out, word_valid_out, busy_out, done_out
   );

   modport master (
      output start_in, conf_in, key_valid_in, ready_in,
      input  key_ready_out, buff_en_out, conf_out, sel_key_out, rot_sub_out,
             sub_only_out, rcon_out, word_idx_out, word_valid_out, busy_out, done_out
   );
endinterface

// File: rtl/key_exp_ctrl.sv
// rtl/key_exp_ctrl.sv - sequencing FSM stepping the AES key-expansion delay line and word logic
module key_exp_ctrl
   import key_exp_pkg::*;
#(
   parameter int SBOX_LAT = 1
) (
   input  logic          clk_in,
   input  logic          rst_in,
   key_exp_ctrl_if.slave bus
);

   localparam logic [2:0] LAT_LAST = (SBOX_LAT > 0) ? 3'(SBOX_LAT - 1) : 3'd0;
   localparam bit         LAT_ZERO = (SBOX_LAT == 0);

   state_e     r_state;
   logic [5:0] r_idx;
   logic [2:0] r_phase;
   logic [7:0] r_rcon;
   logic [2:0] r_subcnt;
   logic [1:0] r_conf;
   logic       r_rot_sub;
   logic       r_sub_only;

   logic [5:0] w_nk;
   logic [5:0] w_total;
   logic [2:0] w_phase_nxt;
   logic       w_rot_nxt;
   logic       w_sub_nxt;
   logic       w_in_load;
   logic       w_in_calc;
   logic       w_valid;
   logic       w_fire;
   logic       w_last_key;
   logic       w_last_word;
   state_e     w_entry_state;

   assign w_nk        = nk_of(r_conf);
   assign w_total     = total_of(r_conf);
   assign w_in_load   = (r_state == ST_LOAD);
   assign w_in_calc   = (r_state == ST_CALC);
   assign w_valid     = w_in_load ? bus.key_valid_in : w_in_calc;
   assign w_fire      = w_valid & bus.ready_in;
   assign w_last_key  = (r_idx == w_nk - 6'd1);
   assign w_last_word = (r_idx == w_total - 6'd1);

   // Phase tracks i mod Nk for the word that follows the current transfer.
   assign w_phase_nxt   = ({3'd0, r_phase} == w_nk - 6'd1) ? 3'd0 : r_phase + 3'd1;
   assign w_rot_nxt     = (w_phase_nxt == 3'd0);
   assign w_sub_nxt     = (r_conf == CONF_256) && (w_phase_nxt == 3'd4);
   assign w_entry_state = ((w_rot_nxt || w_sub_nxt) && !LAT_ZERO) ? ST_WAIT_SUB : ST_CALC;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state    <= ST_IDLE;
         r_idx      <= 6'd0;
         r_phase    <= 3'd0;
         r_rcon     <= RCON_INIT;
         r_subcnt   <= 3'd0;
         r_conf     <= CONF_128;
         r_rot_sub  <= 1'b0;
         r_sub_only <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start_in) begin
                  r_conf     <= conf_norm(bus.conf_in);
                  r_idx      <= 6'd0;
                  r_phase    <= 3'd0;
                  r_subcnt   <= 3'd0;
                  r_rcon     <= RCON_INIT;
                  r_rot_sub  <= 1'b0;
                  r_sub_only <= 1'b0;
                  r_state    <= ST_LOAD;
               end
            end
            ST_LOAD, ST_CALC: begin
               if (w_fire) begin
                  r_idx   <= r_idx + 6'd1;
                  r_phase <= w_phase_nxt;
                  if (w_in_calc && (r_phase == 3'd0)) begin
                     r_rcon <= xtime(r_rcon);
                  end
                  if (w_in_calc && w_last_word) begin
                     r_state    <= ST_DONE;
                     r_rot_sub  <= 1'b0;
                     r_sub_only <= 1'b0;
                  end else if (w_in_calc || w_last_key) begin
                     r_state    <= w_entry_state;
                     r_rot_sub  <= w_rot_nxt;
                     r_sub_only <= w_sub_nxt;
                  end
               end
            end
            // S-box latency is a pipeline delay, so it elapses regardless of ready_in.
            ST_WAIT_SUB: begin
               if (r_subcnt == LAT_LAST) begin
                  r_subcnt <= 3'd0;
                  r_state  <= ST_CALC;
               end else begin
                  r_subcnt <= r_subcnt + 3'd1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.key_ready_out  = w_in_load & bus.key_valid_in & bus.ready_in;
   assign bus.buff_en_out    = w_fire;
   assign bus.conf_out       = r_conf;
   assign bus.sel_key_out    = w_in_load;
   assign bus.rot_sub_out    = r_rot_sub;
   assign bus.sub_only_out   = r_sub_only;
   assign bus.rcon_out       = r_rcon;
   assign bus.word_idx_out   = r_idx;
   assign bus.word_valid_out = w_valid;
   assign bus.busy_out       = (r_state != ST_IDLE);
   assign bus.done_out       = (r_state == ST_DONE);

endmodule

// File: tb/tb_key_exp_ctrl.sv
// tb/tb_key_exp_ctrl.sv - directed self-checking bench for key_exp_ctrl
module tb_key_exp_ctrl;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       tb_start, tb_key_valid, tb_ready;
   logic [1:0] tb_conf;
   int         sel;

   always #5 clk_in = ~clk_in;

   key_exp_ctrl_if if_l1 ();
   key_exp_ctrl_if if_l3 ();
   key_exp_ctrl_if if_l0 ();

   assign if_l1.start_in = tb_start & (sel == 0);
   assign if_l3.start_in = tb_start & (sel == 1);
   assign if_l0.start_in = tb_start & (sel == 2);
   assign if_l1.conf_in = tb_conf;      assign if_l3.conf_in = tb_conf;      assign if_l0.conf_in = tb_conf;
   assign if_l1.key_valid_in = tb_key_valid;
   assign if_l3.key_valid_in = tb_key_valid;
   assign if_l0.key_valid_in = tb_key_valid;
   assign if_l1.ready_in = tb_ready;    assign if_l3.ready_in = tb_ready;    assign if_l0.ready_in = tb_ready;

   key_exp_ctrl #(.SBOX_LAT(1)) dut_l1 (.clk_in(clk_in), .rst_in(rst_in), .bus(if_l1.slave));
   key_exp_ctrl #(.SBOX_LAT(3)) dut_l3 (.clk_in(clk_in), .rst_in(rst_in), .bus(if_l3.slave));
   key_exp_ctrl #(.SBOX_LAT(0)) dut_l0 (.clk_in(clk_in), .rst_in(rst_in), .bus(if_l0.slave));

   logic [23:0] v_l1, v_l3, v_l0, m_vec;
   logic        m_key_ready, m_buff_en, m_sel_key, m_rot_sub, m_sub_only, m_wvalid, m_busy, m_done;
   logic [1:0]  m_conf;
   logic [7:0]  m_rcon;
   logic [5:0]  m_idx;

   assign v_l1 = {if_l1.key_ready_out, if_l1.buff_en_out, if_l1.conf_out, if_l1.sel_key_out,
                  if_l1.rot_sub_out, if_l1.sub_only_out, if_l1.rcon_out, if_l1.word_idx_out,
                  if_l1.word_valid_out, if_l1.busy_out, if_l1.done_out};
   assign v_l3 = {if_l3.key_ready_out, if_l3.buff_en_out, if_l3.conf_out, if_l3.sel_key_out,
                  if_l3.rot_sub_out, if_l3.sub_only_out, if_l3.rcon_out, if_l3.word_idx_out,
                  if_l3.word_valid_out, if_l3.busy_out, if_l3.done_out};
   assign v_l0 = {if_l0.key_ready_out, if_l0.buff_en_out, if_l0.conf_out, if_l0.sel_key_out,
                  if_l0.rot_sub_out, if_l0.sub_only_out, if_l0.rcon_out, if_l0.word_idx_out,
                  if_l0.word_valid_out, if_l0.busy_out, if_l0.done_out};
   assign m_vec = (sel == 1) ? v_l3 : (sel == 2) ? v_l0 : v_l1;
   assign {m_key_ready, m_buff_en, m_conf, m_sel_key, m_rot_sub, m_sub_only,
           m_rcon, m_idx, m_wvalid, m_busy, m_done} = m_vec;

   logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   int errors = 0;
   int checks = 0;
   int n_xfer, n_done, done_cyc, last_xfer, n_bad_buff, n_bad_stall, n_stall, n_key_rdy, conf_seen, exp_lat;
   logic busy_after_done;
   int   rot_q[$];
   int   sub_q[$];
   logic [7:0] rcon_q[$];

   function automatic int rot_bad(input int nk, input int n);
      int bad = (rot_q.size() == n) ? 0 : 1;
      for (int k = 0; k < rot_q.size(); k++) if (rot_q[k] != nk * (k + 1)) bad++;
      return bad;
   endfunction

   function automatic int sub_bad(input int n);
      int bad = (sub_q.size() == n) ? 0 : 1;
      for (int k = 0; k < sub_q.size(); k++) if (sub_q[k] != 12 + 8 * k) bad++;
      return bad;
   endfunction

   function automatic int rcon_bad(input int n);
      int bad = (rcon_q.size() == n) ? 0 : 1;
      for (int k = 0; k < rcon_q.size() && k < 10; k++) if (rcon_q[k] !== rcon_tab[k]) bad++;
      return bad;
   endfunction

   // Runs one full expansion on the selected instance and gathers observations.
   task automatic run_seq(input logic [1:0] conf, input bit tog, input bit gap);
      int  run;
      bit  seen_done;
      run = 0; seen_done = 0;
      n_xfer = 0; n_done = 0; done_cyc = -1; last_xfer = -5; n_bad_buff = 0;
      n_bad_stall = 0; n_stall = 0; n_key_rdy = 0; conf_seen = -1; busy_after_done = 1'b1;
      rot_q.delete(); sub_q.delete(); rcon_q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk_in); #1;
         tb_start     = (cyc == 0);
         tb_conf      = conf;
         tb_ready     = tog ? (cyc % 2 == 1) : 1'b1;
         tb_key_valid = gap ? (cyc % 3 != 1) : 1'b1;
         @(negedge clk_in);
         if (seen_done) begin
            busy_after_done = m_busy;
            break;
         end
         if (m_sel_key) conf_seen = int'(m_conf);
         if (m_buff_en !== (m_wvalid & tb_ready)) n_bad_buff++;
         if (m_buff_en && !tb_ready) n_bad_buff++;
         if (m_key_ready !== (m_sel_key & m_buff_en)) n_bad_buff++;
         if (m_key_ready) n_key_rdy++;
         if (m_busy && !m_done && !m_sel_key && !m_wvalid) begin
            run++;
            n_stall++;
         end
         if (m_buff_en) begin
            n_xfer++;
            last_xfer = cyc;
            if (m_rot_sub) begin
               rot_q.push_back(int'(m_idx));
               rcon_q.push_back(m_rcon);
            end
            if (m_sub_only) sub_q.push_back(int'(m_idx));
            if (!m_sel_key && (((m_rot_sub | m_sub_only) && run != exp_lat) ||
                               (!(m_rot_sub | m_sub_only) && run != 0))) n_bad_stall++;
            run = 0;
         end
         if (m_done) begin
            n_done++;
            done_cyc  = cyc;
            seen_done = 1'b1;
         end
      end
      tb_start = 1'b0; tb_ready = 1'b1; tb_key_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", m_busy); end
      checks++; if (m_rcon !== 8'h01) begin errors++; $display("FAIL reset_rcon: got %0h expected 01", m_rcon); end
      checks++; if (m_idx !== 6'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", m_idx); end
      checks++;
      if ({m_key_ready, m_buff_en, m_conf, m_sel_key, m_rot_sub, m_sub_only, m_wvalid, m_done} !== 9'd0) begin
         errors++; $display("FAIL reset_outputs: got %0h expected 0",
                            {m_key_ready, m_buff_en, m_conf, m_sel_key, m_rot_sub, m_sub_only, m_wvalid, m_done});
      end
      @(posedge clk_in); #1 rst_in = 1'b1;
   endtask

   task automatic test_aes128();
      sel = 0; exp_lat = 1;
      run_seq(2'd0, 1'b0, 1'b0);
      checks++; if (n_xfer != 44) begin errors++; $display("FAIL aes128_xfers: got %0d expected 44", n_xfer); end
      checks++; if (n_key_rdy != 4) begin errors++; $display("FAIL aes128_key_ready: got %0d expected 4", n_key_rdy); end
      checks++; if (rot_bad(4, 10) != 0) begin errors++; $display("FAIL aes128_rot_idx: got %0d entries expected 10 at 4..40", rot_q.size()); end
      checks++; if (rcon_bad(10) != 0) begin errors++; $display("FAIL aes128_rcon: got %0d bad expected 0", rcon_bad(10)); end
      checks++; if (sub_q.size() != 0) begin errors++; $display("FAIL aes128_sub_only: got %0d expected 0", sub_q.size()); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL aes128_done_count: got %0d expected 1", n_done); end
      checks++; if (done_cyc != last_xfer + 1) begin errors++; $display("FAIL aes128_done_timing: got %0d expected %0d", done_cyc, last_xfer + 1); end
      checks++; if (busy_after_done !== 1'b0) begin errors++; $display("FAIL aes128_busy_drop: got %0d expected 0", busy_after_done); end
      checks++; if (n_bad_stall != 0) begin errors++; $display("FAIL aes128_stall: got %0d expected 0", n_bad_stall); end
      checks++; if (n_bad_buff != 0) begin errors++; $display("FAIL aes128_buff_en: got %0d expected 0", n_bad_buff); end
   endtask

   task automatic test_aes256();
      sel = 0; exp_lat = 1;
      run_seq(2'd2, 1'b0, 1'b0);
      checks++; if (n_xfer != 60) begin errors++; $display("FAIL aes256_xfers: got %0d expected 60", n_xfer); end
      checks++; if (rot_bad(8, 7) != 0) begin errors++; $display("FAIL aes256_rot_idx: got %0d entries expected 7 at 8..56", rot_q.size()); end
      checks++; if (sub_bad(6) != 0) begin errors++; $display("FAIL aes256_sub_idx: got %0d entries expected 6 at 12..52", sub_q.size()); end
      checks++; if (rcon_bad(7) != 0) begin errors++; $display("FAIL aes256_rcon: got %0d bad expected 0", rcon_bad(7)); end
      checks++; if (conf_seen != 2) begin errors++; $display("FAIL aes256_conf: got %0d expected 2", conf_seen); end
      checks++; if (n_bad_stall != 0) begin errors++; $display("FAIL aes256_stall: got %0d expected 0", n_bad_stall); end
   endtask

   task automatic test_conf3();
      sel = 0; exp_lat = 1;
      run_seq(2'd3, 1'b0, 1'b0);
      checks++; if (conf_seen != 2) begin errors++; $display("FAIL conf3_conf_out: got %0d expected 2", conf_seen); end
      checks++; if (n_xfer != 60) begin errors++; $display("FAIL conf3_xfers: got %0d expected 60", n_xfer); end
      checks++; if (rot_bad(8, 7) + sub_bad(6) != 0) begin errors++; $display("FAIL conf3_selects: got %0d/%0d expected 7/6", rot_q.size(), sub_q.size()); end
   endtask

   task automatic test_aes192_backpressure();
      sel = 0; exp_lat = 1;
      run_seq(2'd1, 1'b1, 1'b1);
      checks++; if (n_xfer != 52) begin errors++; $display("FAIL aes192_xfers: got %0d expected 52", n_xfer); end
      checks++; if (n_bad_buff != 0) begin errors++; $display("FAIL aes192_buff_en_when_stalled: got %0d expected 0", n_bad_buff); end
      checks++; if (rot_bad(6, 8) != 0) begin errors++; $display("FAIL aes192_rot_idx: got %0d entries expected 8 at 6..48", rot_q.size()); end
      checks++; if (rcon_bad(8) != 0) begin errors++; $display("FAIL aes192_rcon: got %0d bad expected 0", rcon_bad(8)); end
      checks++; if (n_key_rdy != 6) begin errors++; $display("FAIL aes192_key_ready: got %0d expected 6", n_key_rdy); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL aes192_done: got %0d expected 1", n_done); end
   endtask

   task automatic test_sbox_lat();
      sel = 1; exp_lat = 3;
      run_seq(2'd0, 1'b0, 1'b0);
      checks++; if (n_stall != 30) begin errors++; $display("FAIL lat3_stall_total: got %0d expected 30", n_stall); end
      checks++; if (n_bad_stall != 0) begin errors++; $display("FAIL lat3_stall_per_word: got %0d expected 0", n_bad_stall); end
      checks++; if (n_xfer != 44) begin errors++; $display("FAIL lat3_xfers: got %0d expected 44", n_xfer); end
      sel = 2; exp_lat = 0;
      run_seq(2'd0, 1'b0, 1'b0);
      checks++; if (n_stall != 0) begin errors++; $display("FAIL lat0_stall_total: got %0d expected 0", n_stall); end
      checks++; if (n_xfer != 44) begin errors++; $display("FAIL lat0_xfers: got %0d expected 44", n_xfer); end
      checks++; if (rot_bad(4, 10) + rcon_bad(10) != 0) begin errors++; $display("FAIL lat0_rot_rcon: got %0d entries expected 10", rot_q.size()); end
      sel = 0; exp_lat = 1;
   endtask

   task automatic test_reset_midrun();
      int cnt;
      bit hit;
      sel = 0; cnt = 0; hit = 0;
      for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
         @(posedge clk_in); #1;
         tb_start = (cyc == 0); tb_conf = 2'd1; tb_ready = 1'b1; tb_key_valid = 1'b1;
         @(negedge clk_in);
         if (m_buff_en) cnt++;
         if (cnt == 20) hit = 1'b1;
      end
      tb_start = 1'b0;
      @(posedge clk_in); #2;
      checks++; if (m_idx !== 6'd20 || m_conf !== 2'd1) begin errors++; $display("FAIL midrun_pre_reset: got idx %0d conf %0d expected 20 1", m_idx, m_conf); end
      rst_in = 1'b0;
      #1;
      checks++; if (m_idx !== 6'd0 || m_busy !== 1'b0) begin errors++; $display("FAIL midrun_async_idx_busy: got %0d %0d expected 0 0", m_idx, m_busy); end
      checks++; if (m_rcon !== 8'h01 || m_conf !== 2'd0) begin errors++; $display("FAIL midrun_async_rcon_conf: got %0h %0d expected 01 0", m_rcon, m_conf); end
      checks++; if (m_buff_en !== 1'b0 || m_wvalid !== 1'b0) begin errors++; $display("FAIL midrun_async_handshake: got %0d %0d expected 0 0", m_buff_en, m_wvalid); end
      @(posedge clk_in); #1 rst_in = 1'b1;
      exp_lat = 1;
      run_seq(2'd0, 1'b0, 1'b0);
      checks++; if (n_xfer != 44 || n_done != 1) begin errors++; $display("FAIL midrun_restart: got %0d xfers %0d done expected 44 1", n_xfer, n_done); end
      checks++; if (rot_bad(4, 10) + rcon_bad(10) != 0) begin errors++; $display("FAIL midrun_restart_seq: got %0d entries expected 10", rot_q.size()); end
   endtask

   task automatic test_start_while_busy();
      int  cnt;
      bit  fin;
      sel = 0; cnt = 0; fin = 0;
      for (int cyc = 0; cyc < 200 && cnt < 10; cyc++) begin
         @(posedge clk_in); #1;
         tb_start = (cyc == 0); tb_conf = 2'd0; tb_ready = 1'b1; tb_key_valid = 1'b1;
         @(negedge clk_in);
         if (m_buff_en) cnt++;
      end
      @(posedge clk_in); #1;
      tb_ready = 1'b0; tb_start = 1'b1; tb_conf = 2'd2;
      @(negedge clk_in);
      checks++; if (m_buff_en !== 1'b0) begin errors++; $display("FAIL busy_start_buff_en: got %0d expected 0", m_buff_en); end
      @(posedge clk_in); #1 tb_start = 1'b0;
      @(negedge clk_in);
      checks++; if (m_idx !== 6'd10) begin errors++; $display("FAIL busy_start_idx: got %0d expected 10", m_idx); end
      checks++; if (m_conf !== 2'd0 || m_busy !== 1'b1) begin errors++; $display("FAIL busy_start_conf: got %0d busy %0d expected 0 1", m_conf, m_busy); end
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         @(posedge clk_in); #1 tb_ready = 1'b1;
         @(negedge clk_in);
         if (m_buff_en) cnt++;
         if (m_done) fin = 1'b1;
      end
      checks++; if (!fin || cnt != 44) begin errors++; $display("FAIL busy_start_completion: got done %0d xfers %0d expected 1 44", fin, cnt); end
   endtask

   initial begin
      sel = 0; tb_start = 1'b0; tb_conf = 2'd0; tb_key_valid = 1'b1; tb_ready = 1'b1;
      exp_lat = 1;
      test_reset();
      test_aes128();
      test_aes256();
      test_conf3();
      test_aes192_backpressure();
      test_sbox_lat();
      test_reset_midrun();
      test_start_while_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
